reorder_pingpong: RTL and testbench

REORDER_PINGPONG -- requirements
Module: reorder_pingpong

---
 rtl/reorder_pingpong.sv | 176 +++++++++++++++++
 tb/tb_reorder_pingpong.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_pingpong.sv
// -----------------------------------------------------------------------------
// reorder_pingpong
//
// Ping-pong frame buffer that reorders complex I/Q samples. A frame of
// N = 2^log2n samples is written into one of two banks, either at bit-reversed
// addresses (rev_en=1) or at natural addresses (rev_en=0). Once the frame is
// complete, the bank is read out in natural address order, one sample per
// cycle. Frames alternate between the two banks, so input and output can
// stream concurrently without stalls.
//
// Parameters
//   WIDTH      signed sample width per I/Q component
//   MAX_LOG2N  log2 of the largest frame; bank depth is 2^MAX_LOG2N (<= 15)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   log2n          requested frame-size exponent (clamped to 3..MAX_LOG2N)
//   rev_en         1 = bit-reversed reorder, 0 = natural pass-through
//   di_re, di_im   input sample
//   di_en          input sample valid
//   di_rdy         a sample can be accepted this cycle
//   do_re, do_im   registered output sample (zero when do_en is low)
//   do_en          output sample valid
//   do_last        final sample of the output frame
//   ovf            sticky: a sample was offered while di_rdy was low
// -----------------------------------------------------------------------------
module reorder_pingpong #(
  parameter int WIDTH     = 18,
  parameter int MAX_LOG2N = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              log2n,
  input  logic                    rev_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  output logic                    di_rdy,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  output logic                    do_last,
  output logic                    ovf
);

  localparam int AW    = MAX_LOG2N;
  localparam int DEPTH = 1 << MAX_LOG2N;

  typedef logic [AW-1:0] addr_t;

  // Frame-size exponent limited to the supported range 3..MAX_LOG2N.
  function automatic logic [3:0] clamp_log2n(input logic [3:0] l);
    if (l < 4'd3) return 4'd3;
    if (int'(l) > MAX_LOG2N) return 4'(MAX_LOG2N);
    return l;
  endfunction

  // Index of the final sample of an N = 2^l frame (N-1, as an address).
  function automatic addr_t last_index(input logic [3:0] l);
    return addr_t'({AW{1'b1}} >> (AW - int'(l)));
  endfunction

  // Reverse k over l bits: mirror across the full address width, then shift
  // the result down so only the low l bits are populated.
  function automatic addr_t bit_reverse(input addr_t k, input logic [3:0] l);
    addr_t r;
    for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
    return addr_t'(r >> (AW - int'(l)));
  endfunction

  logic [2*WIDTH-1:0] mem [2][DEPTH];

  // Write-side state
  logic       wr_bank;
  addr_t      wr_cnt;
  logic [3:0] wr_log2n;
  logic       wr_rev;

  // Per-bank state: full flag and the frame size held until readout ends
  logic [1:0] bank_full;
  logic [3:0] bank_log2n [2];

  // Read-side state
  logic       rd_bank;
  addr_t      rd_cnt;

  logic             accept;
  logic [3:0]       frame_log2n;
  logic             frame_rev;
  addr_t            wr_addr;
  logic             wr_done;
  logic [2*WIDTH-1:0] rd_word;

  // A bank stays full until its last sample has been output, so "full"
  // already covers "being read".
  assign di_rdy = ~bank_full[wr_bank];
  assign accept = di_en & di_rdy;

  // The first sample of a frame uses the live log2n/rev_en; later samples use
  // the values latched with that first sample.
  assign frame_log2n = (wr_cnt == '0) ? clamp_log2n(log2n) : wr_log2n;
  assign frame_rev   = (wr_cnt == '0) ? rev_en : wr_rev;
  assign wr_addr     = frame_rev ? bit_reverse(wr_cnt, frame_log2n) : wr_cnt;
  assign wr_done     = (wr_cnt == last_index(frame_log2n));

  assign rd_word = mem[rd_bank][rd_cnt];

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (rst && accept) mem[wr_bank][wr_addr] <= {di_re, di_im};
  end

  // Control: write counting, bank hand-off and the read engine. Reading
  // simply follows the bank pointer: whenever the bank at rd_bank is full it
  // is streamed out. After the last sample the pointer flips, so a frame that
  // completed meanwhile starts on the very next edge with no idle cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      wr_log2n      <= 4'd3;
      wr_rev        <= 1'b0;
      bank_full     <= 2'b00;
      bank_log2n[0] <= 4'd3;
      bank_log2n[1] <= 4'd3;
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
      do_re         <= '0;
      do_im         <= '0;
      do_en         <= 1'b0;
      do_last       <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      if (di_en && !di_rdy) ovf <= 1'b1;

      if (accept) begin
        if (wr_cnt == '0) begin
          wr_log2n            <= frame_log2n;
          wr_rev              <= rev_en;
          bank_log2n[wr_bank] <= frame_log2n;
        end
        if (wr_done) begin
          bank_full[wr_bank] <= 1'b1;
          wr_cnt             <= '0;
          wr_bank            <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // Write completion and read release never target the same bank on one
      // edge: a write needs an empty bank, a read needs a full one.
      if (bank_full[rd_bank]) begin
        do_en <= 1'b1;
        do_re <= rd_word[2*WIDTH-1:WIDTH];
        do_im <= rd_word[WIDTH-1:0];
        if (rd_cnt == last_index(bank_log2n[rd_bank])) begin
          do_last            <= 1'b1;
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= ~rd_bank;
          rd_cnt             <= '0;
        end else begin
          do_last <= 1'b0;
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end else begin
        do_en   <= 1'b0;
        do_re   <= '0;
        do_im   <= '0;
        do_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_pingpong.sv
// -----------------------------------------------------------------------------
// tb_reorder_pingpong
//
// Scoreboard bench for reorder_pingpong. The driver feeds samples and a
// frame-level reference model; whenever the model sees a frame complete it
// pushes the whole expected output frame into a queue. An independent monitor
// pops and compares every valid output sample.
// -----------------------------------------------------------------------------
module tb_reorder_pingpong;

  localparam int W  = 18;
  localparam int ML = 7;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic [3:0]   log2n  = 4'd0;
  logic         rev_en = 1'b0;
  logic [W-1:0] di_re  = '0;
  logic [W-1:0] di_im  = '0;
  logic         di_en  = 1'b0;
  logic         di_rdy;
  logic [W-1:0] do_re;
  logic [W-1:0] do_im;
  logic         do_en;
  logic         do_last;
  logic         ovf;

  reorder_pingpong #(.WIDTH(W), .MAX_LOG2N(ML)) dut (
    .clk     (clk),
    .rst     (rst),
    .log2n   (log2n),
    .rev_en  (rev_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .di_en   (di_en),
    .di_rdy  (di_rdy),
    .do_re   (do_re),
    .do_im   (do_im),
    .do_en   (do_en),
    .do_last (do_last),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   total     = 0;
  int   bad       = 0;
  bit   mon_on    = 1'b0;
  int   pop_count = 0;
  int   run_len   = 0;
  int   rdy_waits = 0;

  // Reference model state: samples of the frame currently being collected
  int           m_cnt = 0;
  int           m_l2  = 3;
  bit           m_rev = 1'b0;
  logic [W-1:0] m_re [128];
  logic [W-1:0] m_im [128];

  function automatic int clampL2(input int l);
    if (l < 3) return 3;
    if (l > ML) return ML;
    return l;
  endfunction

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Output position j of a reordered frame carries input sample brev(j).
  task automatic modelAccept(input logic [W-1:0] re, input logic [W-1:0] im,
                             input int l2, input bit rev);
    if (m_cnt == 0) begin
      m_l2  = clampL2(l2);
      m_rev = rev;
    end
    m_re[m_cnt] = re;
    m_im[m_cnt] = im;
    m_cnt++;
    if (m_cnt == (1 << m_l2)) begin
      for (int j = 0; j < m_cnt; j++) begin
        exp_t e;
        int   src;
        src    = m_rev ? brev(j, m_l2) : j;
        e.re   = m_re[src];
        e.im   = m_im[src];
        e.last = (j == m_cnt - 1);
        exp_q.push_back(e);
      end
      m_cnt = 0;
    end
  endtask

  // Offers one sample, waiting (bounded) for di_rdy so nothing is dropped.
  task automatic applyStimulus(input logic [W-1:0] re, input logic [W-1:0] im,
                               input int l2, input bit rev);
    int waited = 0;
    @(negedge clk);
    while (di_rdy !== 1'b1 && waited < 1000) begin
      di_en = 1'b0;
      waited++;
      rdy_waits++;
      @(negedge clk);
    end
    if (waited >= 1000) begin
      checkOutput("rdy_timeout", {63'd0, di_rdy}, 64'd1);
      return;
    end
    di_en  = 1'b1;
    di_re  = re;
    di_im  = im;
    log2n  = 4'(l2);
    rev_en = rev;
    @(posedge clk);
    modelAccept(re, im, l2, rev);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      di_en = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      di_en = 1'b0;
      n++;
    end
    idle(3);
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    di_en = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every valid output must match the next expected
  // entry; idle cycles must present zero data.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (do_en === 1'b1) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_out", {63'd0, do_en}, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            pop_count++;
            checkOutput("out_re", 64'(do_re), 64'(e.re));
            checkOutput("out_im", 64'(do_im), 64'(e.im));
            checkOutput("out_last", {63'd0, do_last}, {63'd0, e.last});
          end
        end else begin
          checkOutput("idle_zero", 64'({do_re, do_im, do_last}), 64'd0);
        end
      end
    end
  end

  // Length of the current unbroken run of valid output cycles.
  initial begin
    forever begin
      @(posedge clk);
      run_len = (do_en === 1'b1) ? run_len + 1 : 0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int maxRun;
    int base;
    int n;
    int cnt;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b1;
    checkOutput("rst_do_en",   {63'd0, do_en},   64'd0);
    checkOutput("rst_do_last", {63'd0, do_last}, 64'd0);
    checkOutput("rst_ovf",     {63'd0, ovf},     64'd0);
    checkOutput("rst_do_re",   64'(do_re),       64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_di_rdy",  {63'd0, di_rdy},  64'd1);

    // 128-point bit-reversed frame with di_re = k, plus first-output latency
    $display("[TB] 128-point bit-reversed frame");
    for (int k = 0; k < 128; k++) applyStimulus(W'(k), W'(1000 + k), 7, 1'b1);
    @(negedge clk);
    di_en = 1'b0;
    checkOutput("lat_idle", {63'd0, do_en}, 64'd0);
    @(negedge clk);
    checkOutput("lat_first_en", {63'd0, do_en}, 64'd1);
    checkOutput("lat_first_re", 64'(do_re), 64'd0);
    @(negedge clk);
    checkOutput("lat_second_re", 64'(do_re), 64'd64);
    waitDrain();

    // Three back-to-back 128-point frames at full rate
    $display("[TB] sustained back-to-back frames");
    rdy_waits = 0;
    for (int f = 0; f < 3; f++) begin
      bit r;
      r = 1'($urandom_range(0, 1));
      for (int k = 0; k < 128; k++)
        applyStimulus(W'($urandom), W'($urandom), 7, r);
    end
    checkOutput("sustain_rdy_waits", 64'(rdy_waits), 64'd0);
    maxRun = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      di_en = 1'b0;
      if (run_len > maxRun) maxRun = run_len;
    end
    checkOutput("sustain_run", 64'(maxRun), 64'd384);
    checkOutput("sustain_ovf", {63'd0, ovf}, 64'd0);
    waitDrain();

    // 8-point natural-order frame with idle gaps
    $display("[TB] 8-point pass-through with gaps");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(W'(10 + k), W'(k), 3, 1'b0);
      idle($urandom_range(0, 3));
    end
    waitDrain();

    // Oversized exponent is clamped to the largest frame
    $display("[TB] log2n=15 clamp");
    for (int k = 0; k < 128; k++)
      applyStimulus(W'($urandom), W'($urandom), 15, 1'b1);
    waitDrain();

    // Random frame sizes, gaps, and mid-frame parameter churn
    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      int l2;
      bit r;
      int fn;
      l2 = $urandom_range(1, 9);
      r  = 1'($urandom_range(0, 1));
      fn = 1 << clampL2(l2);
      for (int k = 0; k < fn; k++) begin
        if (k == 0) applyStimulus(W'($urandom), W'($urandom), l2, r);
        else applyStimulus(W'($urandom), W'($urandom), $urandom_range(0, 15),
                           1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    checkOutput("rand_ovf", {63'd0, ovf}, 64'd0);
    waitDrain();

    // Small frame blocked behind the readout of a large one
    $display("[TB] blocking and overflow");
    doReset();
    for (int k = 0; k < 128; k++) applyStimulus(W'($urandom), W'($urandom), 7, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(W'($urandom), W'($urandom), 3, 1'b1);
    @(negedge clk);
    checkOutput("block_rdy_low", {63'd0, di_rdy}, 64'd0);
    di_en  = 1'b1;
    di_re  = W'(999);
    log2n  = 4'd3;
    rev_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    di_en = 1'b0;
    checkOutput("block_ovf", {63'd0, ovf}, 64'd1);
    n = 0;
    while (di_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("block_release_last", {63'd0, do_last}, 64'd1);
    for (int k = 0; k < 8; k++) applyStimulus(W'(200 + k), W'(k), 3, 1'b0);
    checkOutput("block_ovf_sticky", {63'd0, ovf}, 64'd1);
    waitDrain();

    // Reset in the middle of a readout
    $display("[TB] reset during readout");
    doReset();
    checkOutput("rst_ovf_clear", {63'd0, ovf}, 64'd0);
    for (int k = 0; k < 128; k++) applyStimulus(W'($urandom), W'($urandom), 7, 1'b1);
    base = pop_count;
    n = 0;
    while (pop_count < base + 50 && n < 400) begin
      @(negedge clk);
      di_en = 1'b0;
      n++;
    end
    checkOutput("mid_read_reached", 64'(pop_count - base >= 50), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_do_en",   {63'd0, do_en},   64'd0);
    checkOutput("mid_rst_do_re",   64'(do_re),       64'd0);
    checkOutput("mid_rst_do_im",   64'(do_im),       64'd0);
    checkOutput("mid_rst_do_last", {63'd0, do_last}, 64'd0);
    exp_q.delete();
    m_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rdy", {63'd0, di_rdy}, 64'd1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (do_en === 1'b1) cnt++;
    end
    checkOutput("post_rst_silent", 64'(cnt), 64'd0);

    // A fresh frame after reset streams normally
    for (int k = 0; k < 8; k++) applyStimulus(W'($urandom), W'($urandom), 3, 1'b1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
